// File: rtl/pio_svc_pkg.sv
// Shared definitions for the PIO edge-irq servicer: register offsets,
// FSM state encoding and the serviced-event counter width.
package pio_svc_pkg;

    localparam logic [1:0] PIO_OFF_DATA = 2'd0;
    localparam logic [1:0] PIO_OFF_MASK = 2'd2;
    localparam logic [1:0] PIO_OFF_EDGE = 2'd3;

    localparam int SVC_CNT_W = 16;

    typedef enum logic [2:0] {
        INIT_MASK,
        IDLE,
        RD_REQ,
        RD_WAIT,
        CLR_WR,
        PUSH,
        GUARD
    } svc_state_t;

endpackage

// File: rtl/pio_edge_irq_servicer_if.sv
// Avalon-MM link between the servicer (master) and the keys PIO slave,
// plus the PIO level interrupt that travels alongside it.
//   pio_irq        : PIO -> servicer, level irq
//   avm_address    : PIO register offset
//   avm_chipselect : slave select
//   avm_write_n    : active-low write strobe
//   avm_writedata  : write data
//   avm_readdata   : registered read data from the PIO
interface pio_edge_irq_servicer_if;

    logic        pio_irq;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    modport master (
        input  pio_irq,
        input  avm_readdata,
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata
    );

    modport slave (
        output pio_irq,
        output avm_readdata,
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata
    );

endinterface

// File: rtl/pio_svc_evt_reg.sv
// Event holding register: loads captured edge bits, presents them on a
// valid/ready stream and keeps a saturating count of accepted events.
//   load/load_data : capture a new event (only while no event is held)
//   evt_ready      : consumer accepts the held event
//   evt_valid/evt_data : held event
//   serviced_cnt   : accepted events, saturating at all-ones
//   accepted       : handshake pulse (evt_valid & evt_ready)
module pio_svc_evt_reg
    import pio_svc_pkg::*;
#(
    parameter int                   WIDTH   = 4,
    parameter logic [SVC_CNT_W-1:0] CNT_RST = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_data,
    input  logic                 evt_ready,
    output logic                 evt_valid,
    output logic [WIDTH-1:0]     evt_data,
    output logic [SVC_CNT_W-1:0] serviced_cnt,
    output logic                 accepted
);

    assign accepted = evt_valid & evt_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid    <= 1'b0;
            evt_data     <= '0;
            serviced_cnt <= CNT_RST;
        end else begin
            if (load) begin
                evt_valid <= 1'b1;
                evt_data  <= load_data;
            end else if (accepted) begin
                evt_valid <= 1'b0;
            end
            if (accepted && serviced_cnt != '1) begin
                serviced_cnt <= serviced_cnt + SVC_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pio_edge_irq_servicer.sv
// Hardware ISR for a 4-bit edge-capturing keys PIO: programs irq_mask
// after reset, then on each irq reads and clears edge_capture and emits
// the captured bits as a valid/ready event.
// Ports: clk, reset_n (async, active-low), bus (Avalon master + pio_irq),
//   evt_valid/evt_ready/evt_data event stream, serviced_cnt.
// Optional: PIO_EDGE_IRQ_SERVICER_TIMESTAMP_EN adds evt_timestamp[31:0],
//   the free-running cycle count latched when the irq is sampled.
module pio_edge_irq_servicer
    import pio_svc_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter logic [WIDTH-1:0] IRQ_MASK_INIT = 4'hF,
    parameter int               READ_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pio_edge_irq_servicer_if.master bus,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [WIDTH-1:0]        evt_data,
    output logic [SVC_CNT_W-1:0]    serviced_cnt
`ifdef PIO_EDGE_IRQ_SERVICER_TIMESTAMP_EN
    ,
    output logic [31:0]             evt_timestamp
`endif
);

    svc_state_t       state;
    logic [1:0]       addr_q;
    logic             cs_q;
    logic             wn_q;
    logic [31:0]      wd_q;
    logic [1:0]       lat_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] rd_cap;
    logic             accepted;
    logic             unused_rd;

    assign rd_cap    = bus.avm_readdata[WIDTH-1:0] & IRQ_MASK_INIT;
    assign unused_rd = ^bus.avm_readdata[31:WIDTH];

    assign bus.avm_address    = addr_q;
    assign bus.avm_chipselect = cs_q;
    assign bus.avm_write_n    = wn_q;
    assign bus.avm_writedata  = wd_q;

    // Bus outputs are registered on entry to the state that owns the
    // transfer, so they are visible for exactly that state's cycle.
    // The mask write is the exception: reset keeps the bus quiet, so it
    // is issued from the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= INIT_MASK;
            addr_q <= '0;
            cs_q   <= 1'b0;
            wn_q   <= 1'b1;
            wd_q   <= '0;
            lat_q  <= '0;
            cap_q  <= '0;
        end else begin
            cs_q <= 1'b0;
            wn_q <= 1'b1;
            wd_q <= '0;
            unique case (state)
                INIT_MASK: begin
                    cs_q   <= 1'b1;
                    wn_q   <= 1'b0;
                    addr_q <= PIO_OFF_MASK;
                    wd_q   <= {{(32-WIDTH){1'b0}}, IRQ_MASK_INIT};
                    state  <= IDLE;
                end
                IDLE: begin
                    if (bus.pio_irq) begin
                        cs_q   <= 1'b1;
                        addr_q <= PIO_OFF_EDGE;
                        state  <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    lat_q <= 2'(READ_LATENCY);
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    // Counter hits zero on this edge: readdata is valid.
                    if (lat_q == 2'd1) begin
                        cap_q <= rd_cap;
                        if (rd_cap == '0) begin
                            state <= GUARD;
                        end else begin
                            cs_q   <= 1'b1;
                            wn_q   <= 1'b0;
                            addr_q <= PIO_OFF_EDGE;
                            state  <= CLR_WR;
                        end
                    end else begin
                        lat_q <= lat_q - 2'd1;
                    end
                end
                CLR_WR: begin
                    state <= PUSH;
                end
                PUSH: begin
                    if (accepted) begin
                        state <= GUARD;
                    end
                end
                GUARD: begin
                    // pio_irq can still read stale-high right after the
                    // clear write; skip one cycle before sampling again.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    pio_svc_evt_reg #(
        .WIDTH   (WIDTH),
        .CNT_RST ('0)
    ) u_evt (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (state == CLR_WR),
        .load_data    (cap_q),
        .evt_ready    (evt_ready),
        .evt_valid    (evt_valid),
        .evt_data     (evt_data),
        .serviced_cnt (serviced_cnt),
        .accepted     (accepted)
    );

`ifdef PIO_EDGE_IRQ_SERVICER_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_q;

    // ts_q only moves in IDLE, so it stays put while an event is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (state == IDLE && bus.pio_irq) begin
                ts_q <= ts_cnt;
            end
        end
    end

    assign evt_timestamp = ts_q;
`else
    // No timestamp: the event stream carries only the edge bits.
`endif

endmodule

// File: tb/tb_pio_edge_irq_servicer.sv
// Directed bench for pio_edge_irq_servicer with a behavioural keys PIO
// (edge capture, irq mask, registered read data).
module tb_pio_edge_irq_servicer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_data;
    logic [15:0] serviced_cnt;
`ifdef PIO_EDGE_IRQ_SERVICER_TIMESTAMP_EN
    logic [31:0] evt_timestamp;
    logic [31:0] tb_cyc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_edge_irq_servicer_if bus ();

    pio_edge_irq_servicer #(
        .WIDTH         (4),
        .IRQ_MASK_INIT (4'hF),
        .READ_LATENCY  (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_data      (evt_data),
        .serviced_cnt  (serviced_cnt)
`ifdef PIO_EDGE_IRQ_SERVICER_TIMESTAMP_EN
        ,
        .evt_timestamp (evt_timestamp)
`endif
    );

    // Standalone event register preloaded near saturation.
    logic        s_load;
    logic [3:0]  s_ldata;
    logic        s_ready;
    logic        s_valid;
    logic [3:0]  s_data;
    logic [15:0] s_cnt;
    logic        s_acc;

    pio_svc_evt_reg #(
        .WIDTH   (4),
        .CNT_RST (16'hFFFD)
    ) u_sat (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (s_load),
        .load_data    (s_ldata),
        .evt_ready    (s_ready),
        .evt_valid    (s_valid),
        .evt_data     (s_data),
        .serviced_cnt (s_cnt),
        .accepted     (s_acc)
    );

    // Keys PIO model.
    logic [3:0]  keys;
    logic [3:0]  keys_d;
    logic [3:0]  edge_cap;
    logic [3:0]  mask;
    logic [31:0] rd;
    logic        irq_force;

    assign bus.avm_readdata = rd;
    assign bus.pio_irq      = (|(edge_cap & mask)) | irq_force;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keys_d   <= '0;
            edge_cap <= '0;
            mask     <= '0;
            rd       <= '0;
        end else begin
            keys_d <= keys;
            if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd2)
                mask <= bus.avm_writedata[3:0];
            edge_cap <= ((bus.avm_chipselect && !bus.avm_write_n &&
                          bus.avm_address == 2'd3) ? 4'b0 : edge_cap) |
                        (keys & ~keys_d);
            if (bus.avm_chipselect && bus.avm_write_n)
                rd <= (bus.avm_address == 2'd3) ? {28'b0, edge_cap} : 32'b0;
        end
    end

`ifdef PIO_EDGE_IRQ_SERVICER_TIMESTAMP_EN
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cyc <= '0;
        else          tb_cyc <= tb_cyc + 32'd1;
    end
`endif

    // Bus and stream monitors (cumulative; tasks use deltas).
    int          wr2 = 0;
    int          wr3 = 0;
    int          rd3 = 0;
    logic [31:0] wr3_data = '0;
    logic [3:0]  acc_q[$];

    always @(posedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.avm_chipselect) begin
                if (!bus.avm_write_n) begin
                    if (bus.avm_address == 2'd2) wr2++;
                    if (bus.avm_address == 2'd3) begin
                        wr3++;
                        wr3_data = bus.avm_writedata;
                    end
                end else if (bus.avm_address == 2'd3) begin
                    rd3++;
                end
            end
            if (evt_valid && evt_ready) acc_q.push_back(evt_data);
        end
    end

    task automatic test_reset();
        int b2;
        reset_n = 1'b0; evt_ready = 1'b0; keys = '0; irq_force = 1'b0;
        s_load = 1'b0; s_ldata = '0; s_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.avm_chipselect !== 1'b0 || bus.avm_write_n !== 1'b1 ||
            bus.avm_address !== 2'd0 || bus.avm_writedata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus cs=%b wn=%b addr=%0d wd=%h expected 0 1 0 0",
                     bus.avm_chipselect, bus.avm_write_n, bus.avm_address,
                     bus.avm_writedata);
        end
        checks++;
        if (evt_valid !== 1'b0 || evt_data !== 4'h0 || serviced_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_evt valid=%b data=%h cnt=%h expected 0 0 0",
                     evt_valid, evt_data, serviced_cnt);
        end
        b2 = wr2;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.avm_chipselect !== 1'b1 || bus.avm_write_n !== 1'b0 ||
            bus.avm_address !== 2'd2 || bus.avm_writedata !== 32'h0000000F) begin
            errors++;
            $display("FAIL mask_write cs=%b wn=%b addr=%0d wd=%h expected 1 0 2 0000000f",
                     bus.avm_chipselect, bus.avm_write_n, bus.avm_address,
                     bus.avm_writedata);
        end
        @(negedge clk);
        checks++;
        if (bus.avm_chipselect !== 1'b0 || bus.avm_write_n !== 1'b1) begin
            errors++;
            $display("FAIL bus_idle_after_mask cs=%b wn=%b expected 0 1",
                     bus.avm_chipselect, bus.avm_write_n);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (wr2 - b2 !== 1) begin
            errors++;
            $display("FAIL mask_write_count got %0d expected 1", wr2 - b2);
        end
    endtask

    task automatic test_single_event();
        int b3w, b3r, ba, first, vcyc;
        logic [3:0] dseen;
`ifdef PIO_EDGE_IRQ_SERVICER_TIMESTAMP_EN
        logic [31:0] ts_exp, ts_seen;
        ts_seen = '0;
        ts_exp  = tb_cyc + 32'd1;
`endif
        b3w = wr3; b3r = rd3; ba = acc_q.size();
        first = -1; vcyc = 0; dseen = '0;
        evt_ready = 1'b1;
        keys = 4'b0010;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 2) keys = '0;
            if (evt_valid) begin
                if (first < 0) first = i;
                vcyc++;
                dseen = evt_data;
`ifdef PIO_EDGE_IRQ_SERVICER_TIMESTAMP_EN
                ts_seen = evt_timestamp;
`endif
            end
        end
        checks++;
        if (first !== 5) begin
            errors++;
            $display("FAIL single_latency got %0d expected 5", first);
        end
        checks++;
        if (vcyc !== 1 || dseen !== 4'b0010) begin
            errors++;
            $display("FAIL single_event cycles=%0d data=%b expected 1 0010", vcyc, dseen);
        end
        checks++;
        if (serviced_cnt !== 16'd1 || acc_q.size() - ba !== 1) begin
            errors++;
            $display("FAIL single_count cnt=%0d acc=%0d expected 1 1",
                     serviced_cnt, acc_q.size() - ba);
        end
        checks++;
        if (rd3 - b3r !== 1 || wr3 - b3w !== 1 || wr3_data !== 32'h0) begin
            errors++;
            $display("FAIL single_bus reads=%0d writes=%0d wd=%h expected 1 1 0",
                     rd3 - b3r, wr3 - b3w, wr3_data);
        end
`ifdef PIO_EDGE_IRQ_SERVICER_TIMESTAMP_EN
        checks++;
        if (ts_seen !== ts_exp) begin
            errors++;
            $display("FAIL timestamp got %0d expected %0d", ts_seen, ts_exp);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int b3w, ba, bad;
        b3w = wr3; ba = acc_q.size(); bad = 0;
        evt_ready = 1'b0;
        keys = 4'b0001;
        @(negedge clk);
        keys = '0;
        for (int i = 0; i < 10 && !evt_valid; i++) @(negedge clk);
        checks++;
        if (evt_valid !== 1'b1 || evt_data !== 4'b0001) begin
            errors++;
            $display("FAIL bp_first valid=%b data=%b expected 1 0001", evt_valid, evt_data);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 3) keys = 4'b0100;
            if (i == 5) keys = '0;
            @(negedge clk);
            if (!(evt_valid === 1'b1 && evt_data === 4'b0001)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_stable unstable_cycles=%0d expected 0", bad);
        end
        checks++;
        if (wr3 - b3w !== 1 || bus.pio_irq !== 1'b1) begin
            errors++;
            $display("FAIL bp_pending clears=%0d irq=%b expected 1 1",
                     wr3 - b3w, bus.pio_irq);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 20 && acc_q.size() - ba < 2; i++) @(negedge clk);
        checks++;
        if (acc_q.size() - ba !== 2 || acc_q[ba] !== 4'b0001 || acc_q[ba+1] !== 4'b0100) begin
            errors++;
            $display("FAIL bp_sequence count=%0d expected 2 events 0001 then 0100",
                     acc_q.size() - ba);
        end
        checks++;
        if (serviced_cnt !== 16'd3) begin
            errors++;
            $display("FAIL bp_count got %0d expected 3", serviced_cnt);
        end
        @(negedge clk);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drop valid=%b expected 0", evt_valid);
        end
    endtask

    task automatic test_spurious();
        int b3w, b3r, ba, vseen;
        repeat (3) @(negedge clk);
        b3w = wr3; b3r = rd3; ba = acc_q.size(); vseen = 0;
        irq_force = 1'b1;
        @(negedge clk);
        irq_force = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (evt_valid) vseen++;
        end
        checks++;
        if (rd3 - b3r !== 1 || wr3 - b3w !== 0 || vseen !== 0) begin
            errors++;
            $display("FAIL spurious reads=%0d clears=%0d valid_cycles=%0d expected 1 0 0",
                     rd3 - b3r, wr3 - b3w, vseen);
        end
        keys = 4'b1000;
        @(negedge clk);
        keys = '0;
        for (int i = 0; i < 15 && acc_q.size() == ba; i++) @(negedge clk);
        checks++;
        if (acc_q.size() - ba !== 1 || acc_q[ba] !== 4'b1000 || serviced_cnt !== 16'd4) begin
            errors++;
            $display("FAIL spurious_recover events=%0d cnt=%0d expected 1 event 1000 cnt 4",
                     acc_q.size() - ba, serviced_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int b2, vseen;
        bit found;
        found = 1'b0; vseen = 0;
        keys = 4'b0001;
        @(negedge clk);
        keys = '0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.avm_chipselect && bus.avm_write_n) found = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (!found || bus.avm_address !== 2'd3 || bus.avm_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL rd_wait_reach found=%b addr=%0d cs=%b expected 1 3 0",
                     found, bus.avm_address, bus.avm_chipselect);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.avm_chipselect !== 1'b0 || bus.avm_write_n !== 1'b1 ||
            bus.avm_address !== 2'd0 || bus.avm_writedata !== 32'h0 ||
            evt_valid !== 1'b0 || serviced_cnt !== 16'h0) begin
            errors++;
            $display("FAIL async_reset addr=%0d cs=%b wn=%b valid=%b cnt=%0d expected 0 0 1 0 0",
                     bus.avm_address, bus.avm_chipselect, bus.avm_write_n,
                     evt_valid, serviced_cnt);
        end
        @(negedge clk);
        b2 = wr2;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (evt_valid) vseen++;
        end
        checks++;
        if (wr2 - b2 !== 1 || vseen !== 0) begin
            errors++;
            $display("FAIL reset_rewrite mask_writes=%0d valid_cycles=%0d expected 1 0",
                     wr2 - b2, vseen);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_c [3];
        exp_c = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
        checks++;
        if (s_cnt !== 16'hFFFD) begin
            errors++;
            $display("FAIL sat_preload got %h expected fffd", s_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            s_ldata = 4'(k + 1);
            s_load = 1'b1;
            @(negedge clk);
            s_load = 1'b0;
            checks++;
            if (s_valid !== 1'b1 || s_data !== 4'(k + 1)) begin
                errors++;
                $display("FAIL sat_load%0d valid=%b data=%h expected 1 %h",
                         k, s_valid, s_data, 4'(k + 1));
            end
            s_ready = 1'b1;
            #1;
            checks++;
            if (s_acc !== 1'b1) begin
                errors++;
                $display("FAIL sat_accept%0d got %b expected 1", k, s_acc);
            end
            @(negedge clk);
            s_ready = 1'b0;
            checks++;
            if (s_cnt !== exp_c[k] || s_valid !== 1'b0) begin
                errors++;
                $display("FAIL sat_count%0d cnt=%h valid=%b expected %h 0",
                         k, s_cnt, s_valid, exp_c[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
